// File: rtl/summand_queue.sv
// Small FIFO that buffers summands ahead of an accumulator and issues each one
// as a registered o_SUMMAND value with a single-cycle o_CLK_ENABLE pulse.
module summand_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET_N,
    input  logic                     i_VALID,
    input  logic [WIDTH-1:0]         i_DATA,
    output logic                     o_READY,
    input  logic                     i_HOLD,
    input  logic                     i_FLUSH,
    output logic                     o_CLK_ENABLE,
    output logic [WIDTH-1:0]         o_SUMMAND,
    output logic [$clog2(DEPTH):0]   o_COUNT,
    output logic                     o_EMPTY,
    output logic                     o_FULL
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             clk_en_q, clk_en_d;
    logic [WIDTH-1:0] summand_q, summand_d;
    logic             ready_en_q;
    logic             push, pop;

    // Handshake: a summand transfers on a rising edge where i_VALID and o_READY
    // are both high and i_FLUSH is low. o_READY depends on registered state only,
    // and ready_en_q keeps it low until the first edge after reset is released.
    assign o_EMPTY      = (count_q == '0);
    assign o_FULL       = (count_q == FULL_COUNT);
    assign o_READY      = ready_en_q && !o_FULL;
    assign o_COUNT      = count_q;
    assign o_CLK_ENABLE = clk_en_q;
    assign o_SUMMAND    = summand_q;

    assign push = i_VALID && o_READY && !i_FLUSH;
    assign pop  = !o_EMPTY && !i_HOLD && !i_FLUSH;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        clk_en_d  = 1'b0;
        summand_d = summand_q;
        if (i_FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                summand_d = mem_q[rd_ptr_q];
                clk_en_d  = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            clk_en_q   <= 1'b0;
            summand_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            clk_en_q   <= clk_en_d;
            summand_q  <= summand_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage is left unreset; stale entries are unreachable once count is zero.
    always_ff @(posedge i_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_DATA;
        end
    end

endmodule

// File: tb/tb_summand_queue.sv
// Directed bench for summand_queue: each task drives one scenario and checks
// outputs at the falling edge, after the rising edge they depend on.
module tb_summand_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             i_CLK;
    logic             i_RESET_N;
    logic             i_VALID;
    logic [WIDTH-1:0] i_DATA;
    logic             o_READY;
    logic             i_HOLD;
    logic             i_FLUSH;
    logic             o_CLK_ENABLE;
    logic [WIDTH-1:0] o_SUMMAND;
    logic [2:0]       o_COUNT;
    logic             o_EMPTY;
    logic             o_FULL;

    int checks = 0;
    int errors = 0;

    summand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_CLK        (i_CLK),
        .i_RESET_N    (i_RESET_N),
        .i_VALID      (i_VALID),
        .i_DATA       (i_DATA),
        .o_READY      (o_READY),
        .i_HOLD       (i_HOLD),
        .i_FLUSH      (i_FLUSH),
        .o_CLK_ENABLE (o_CLK_ENABLE),
        .o_SUMMAND    (o_SUMMAND),
        .o_COUNT      (o_COUNT),
        .o_EMPTY      (o_EMPTY),
        .o_FULL       (o_FULL)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge i_CLK);
        @(negedge i_CLK);
    endtask

    task automatic test_reset();
        i_RESET_N = 1'b0;
        i_VALID   = 1'b0;
        i_DATA    = '0;
        i_HOLD    = 1'b0;
        i_FLUSH   = 1'b0;
        step();
        step();
        checks++;
        if (o_COUNT !== 3'd0 || o_EMPTY !== 1'b1 || o_FULL !== 1'b0) begin
            errors++;
            $display("FAIL reset_status count=%0d empty=%b full=%b required count=0 empty=1 full=0",
                     o_COUNT, o_EMPTY, o_FULL);
        end
        checks++;
        if (o_READY !== 1'b0 || o_CLK_ENABLE !== 1'b0 || o_SUMMAND !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs ready=%b clk_en=%b summand=%h required 0 0 00",
                     o_READY, o_CLK_ENABLE, o_SUMMAND);
        end
        i_RESET_N = 1'b1;
        step();
        checks++;
        if (o_READY !== 1'b1 || o_CLK_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b clk_en=%b required ready=1 clk_en=0",
                     o_READY, o_CLK_ENABLE);
        end
    endtask

    task automatic test_single();
        i_VALID = 1'b1;
        i_DATA  = 8'h10;
        step();
        i_VALID = 1'b0;
        checks++;
        if (o_COUNT !== 3'd1 || o_CLK_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL single_push count=%0d clk_en=%b required count=1 clk_en=0", o_COUNT, o_CLK_ENABLE);
        end
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== 8'h10 || o_COUNT !== 3'd0) begin
            errors++;
            $display("FAIL single_issue clk_en=%b summand=%h count=%0d required 1 10 0",
                     o_CLK_ENABLE, o_SUMMAND, o_COUNT);
        end
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b0 || o_SUMMAND !== 8'h10 || o_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL single_after clk_en=%b summand=%h empty=%b required 0 10 1",
                     o_CLK_ENABLE, o_SUMMAND, o_EMPTY);
        end
    endtask

    task automatic test_hold_full();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp_v;
        i_HOLD = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_VALID = 1'b1;
            i_DATA  = WIDTH'(k);
            exp_q.push_back(WIDTH'(k));
            step();
            checks++;
            if (o_CLK_ENABLE !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_issue edge=%0d clk_en=%b required 0", k, o_CLK_ENABLE);
            end
        end
        i_VALID = 1'b0;
        checks++;
        if (o_FULL !== 1'b1 || o_READY !== 1'b0 || o_COUNT !== 3'd4) begin
            errors++;
            $display("FAIL hold_full full=%b ready=%b count=%0d required 1 0 4", o_FULL, o_READY, o_COUNT);
        end
        i_HOLD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== exp_v) begin
                errors++;
                $display("FAIL hold_drain idx=%0d clk_en=%b summand=%h required 1 %h",
                         k, o_CLK_ENABLE, o_SUMMAND, exp_v);
            end
        end
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b0 || o_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL hold_drained clk_en=%b empty=%b required 0 1", o_CLK_ENABLE, o_EMPTY);
        end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 10; k++) begin
            i_VALID = 1'b1;
            i_DATA  = WIDTH'(8'h20 + k - 1);
            step();
            checks++;
            if (o_COUNT !== 3'd1) begin
                errors++;
                $display("FAIL stream_count edge=%0d count=%0d required 1", k, o_COUNT);
            end
            if (k >= 2) begin
                checks++;
                if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== WIDTH'(8'h20 + k - 2)) begin
                    errors++;
                    $display("FAIL stream_issue edge=%0d clk_en=%b summand=%h required 1 %h",
                             k, o_CLK_ENABLE, o_SUMMAND, 8'h20 + k - 2);
                end
            end
        end
        i_VALID = 1'b0;
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== 8'h29 || o_COUNT !== 3'd0) begin
            errors++;
            $display("FAIL stream_last clk_en=%b summand=%h count=%0d required 1 29 0",
                     o_CLK_ENABLE, o_SUMMAND, o_COUNT);
        end
        step();
    endtask

    task automatic test_flush();
        i_HOLD  = 1'b1;
        i_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_DATA = WIDTH'(8'h31 + k);
            step();
        end
        checks++;
        if (o_COUNT !== 3'd3) begin
            errors++;
            $display("FAIL flush_fill count=%0d required 3", o_COUNT);
        end
        i_HOLD  = 1'b0;
        i_FLUSH = 1'b1;
        i_DATA  = 8'h3F;
        step();
        i_FLUSH = 1'b0;
        i_VALID = 1'b0;
        checks++;
        if (o_COUNT !== 3'd0 || o_CLK_ENABLE !== 1'b0 || o_SUMMAND !== 8'h29 || o_EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL flush_edge count=%0d clk_en=%b summand=%h empty=%b required 0 0 29 1",
                     o_COUNT, o_CLK_ENABLE, o_SUMMAND, o_EMPTY);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (o_CLK_ENABLE !== 1'b0 || o_COUNT !== 3'd0) begin
                errors++;
                $display("FAIL flush_quiet cyc=%0d clk_en=%b count=%0d required 0 0", k, o_CLK_ENABLE, o_COUNT);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_HOLD  = 1'b1;
        i_VALID = 1'b1;
        i_DATA  = 8'h41;
        step();
        i_DATA  = 8'h42;
        step();
        i_VALID = 1'b0;
        i_HOLD  = 1'b0;
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== 8'h41 || o_COUNT !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_pre clk_en=%b summand=%h count=%0d required 1 41 1",
                     o_CLK_ENABLE, o_SUMMAND, o_COUNT);
        end
        #1 i_RESET_N = 1'b0;
        #1;
        checks++;
        if (o_COUNT !== 3'd0 || o_CLK_ENABLE !== 1'b0 || o_SUMMAND !== 8'h00 ||
            o_EMPTY !== 1'b1 || o_FULL !== 1'b0 || o_READY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async count=%0d clk_en=%b summand=%h empty=%b full=%b ready=%b required 0 0 00 1 0 0",
                     o_COUNT, o_CLK_ENABLE, o_SUMMAND, o_EMPTY, o_FULL, o_READY);
        end
        #1 i_RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (o_CLK_ENABLE !== 1'b0 || o_COUNT !== 3'd0) begin
                errors++;
                $display("FAIL rstmid_quiet cyc=%0d clk_en=%b count=%0d required 0 0", k, o_CLK_ENABLE, o_COUNT);
            end
        end
        i_VALID = 1'b1;
        i_DATA  = 8'h55;
        step();
        i_VALID = 1'b0;
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== 8'h55) begin
            errors++;
            $display("FAIL rstmid_new clk_en=%b summand=%h required 1 55", o_CLK_ENABLE, o_SUMMAND);
        end
        step();
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp_v;
        i_HOLD  = 1'b1;
        i_VALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_DATA = WIDTH'(8'h61 + k);
            exp_q.push_back(WIDTH'(8'h61 + k));
            step();
        end
        i_HOLD = 1'b0;
        i_DATA = 8'h6F;
        checks++;
        if (o_READY !== 1'b0 || o_FULL !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_ready ready=%b full=%b required 0 1", o_READY, o_FULL);
        end
        step();
        i_VALID = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (o_COUNT !== 3'd3 || o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== exp_v) begin
            errors++;
            $display("FAIL fullpp_edge count=%0d clk_en=%b summand=%h required 3 1 %h",
                     o_COUNT, o_CLK_ENABLE, o_SUMMAND, exp_v);
        end
        while (exp_q.size() > 0) begin
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (o_CLK_ENABLE !== 1'b1 || o_SUMMAND !== exp_v) begin
                errors++;
                $display("FAIL fullpp_drain clk_en=%b summand=%h required 1 %h", o_CLK_ENABLE, o_SUMMAND, exp_v);
            end
        end
        step();
        checks++;
        if (o_CLK_ENABLE !== 1'b0 || o_EMPTY !== 1'b1 || o_SUMMAND !== 8'h64) begin
            errors++;
            $display("FAIL fullpp_end clk_en=%b empty=%b summand=%h required 0 1 64",
                     o_CLK_ENABLE, o_EMPTY, o_SUMMAND);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_full();
        test_stream();
        test_flush();
        test_reset_mid();
        test_full_push_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
